// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches over a req/ack handshake and decodes fields/immediate.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned branch targets are refused and flagged instead of truncated.
module fetch_unit #(
    parameter int                    WORDSIZE         = 64,
    parameter int                    INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0]   RESET_PC         = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_start,
    input  logic                          pc_we,
    input  logic                          pc_src,
    input  logic [WORDSIZE-1:0]           pc_target,
    output logic                          imem_req,
    output logic [WORDSIZE-1:0]           imem_addr,
    input  logic                          imem_ack,
    input  logic [INSTRUCTION_SIZE-1:0]   imem_rdata,
    output logic [WORDSIZE-1:0]           pc,
    output logic [WORDSIZE-1:0]           pc_plus4,
    output logic [INSTRUCTION_SIZE-1:0]   ir,
    output logic [6:0]                    opcode,
    output logic [4:0]                    rd,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [2:0]                    funct3,
    output logic [6:0]                    funct7,
    output logic [WORDSIZE-1:0]           imm,
    output logic                          instr_valid,
    output logic                          busy,
    output logic                          misalign
);

    localparam logic [INSTRUCTION_SIZE-1:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [WORDSIZE-1:0]         PC_STEP    = WORDSIZE'(4);
    localparam logic [WORDSIZE-1:0]         ALIGN_MASK = ~WORDSIZE'(3);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t                        state_reg;
    logic [WORDSIZE-1:0]           pc_reg;
    logic [WORDSIZE-1:0]           pc_next;
    logic [INSTRUCTION_SIZE-1:0]   ir_reg;
    logic                          instr_valid_reg;
    logic                          imem_req_reg;
    logic                          busy_reg;
    logic                          target_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic                          misalign_reg;

    assign target_misaligned = pc_src && (pc_target[1:0] != 2'b00);
    assign pc_next           = pc_src ? pc_target : pc_plus4;
    assign misalign          = misalign_reg;
`else
    assign target_misaligned = 1'b0;
    assign pc_next           = pc_src ? (pc_target & ALIGN_MASK) : pc_plus4;
    assign misalign          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            pc_reg          <= RESET_PC;
            ir_reg          <= NOP_INSTR;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b0;
            busy_reg        <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (fetch_start) begin
                        state_reg    <= S_REQ;
                        imem_req_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        state_reg       <= S_VALID;
                        ir_reg          <= imem_rdata;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                S_VALID: begin
                    // Retire wins over any fetch_start arriving in the same cycle.
                    if (pc_we) begin
                        state_reg       <= S_IDLE;
                        instr_valid_reg <= 1'b0;
                        busy_reg        <= 1'b0;
                        if (!target_misaligned) begin
                            pc_reg <= pc_next;
                        end
`ifdef FETCH_MISALIGN_CHECK_EN
                        else begin
                            misalign_reg <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign pc          = pc_reg;
    assign pc_plus4    = pc_reg + PC_STEP;
    assign imem_addr   = pc_reg;
    assign imem_req    = imem_req_reg;
    assign ir          = ir_reg;
    assign instr_valid = instr_valid_reg;
    assign busy        = busy_reg;

    assign opcode = ir_reg[6:0];
    assign rd     = ir_reg[11:7];
    assign funct3 = ir_reg[14:12];
    assign rs1    = ir_reg[19:15];
    assign rs2    = ir_reg[24:20];
    assign funct7 = ir_reg[31:25];

    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{(WORDSIZE-12){ir_reg[31]}}, ir_reg[31:20]};
            OP_STORE:
                imm = {{(WORDSIZE-12){ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
            OP_BRANCH:
                imm = {{(WORDSIZE-13){ir_reg[31]}}, ir_reg[31], ir_reg[7],
                       ir_reg[30:25], ir_reg[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {{(WORDSIZE-32){ir_reg[31]}}, ir_reg[31:12], 12'b0};
            OP_JAL:
                imm = {{(WORDSIZE-21){ir_reg[31]}}, ir_reg[31], ir_reg[19:12],
                       ir_reg[20], ir_reg[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle RISC-V core, directly upstream of the control unit. It owns the program counter and instruction register, fetches one 32-bit instruction per request over a req/ack handshake to instruction memory, and presents the opcode, register indices, function fields and sign-extended immediate to the control unit and datapath. It advances the PC to PC+4 or to a branch/jump target when commanded at the end of write-back.

## Interface
- WORDSIZE, 64, data/address width of PC and immediate
- INSTRUCTION_SIZE, 32, instruction width; only 32 is supported
- RESET_PC, 0, PC value loaded at reset
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_start  in  1  single-cycle pulse from control unit requesting a fetch
- pc_we  in  1  single-cycle pulse: commit next PC and retire current instruction
- pc_src  in  1  0: next PC = PC+4; 1: next PC = pc_target
- pc_target  in  WORDSIZE  branch/jump target from datapath
- imem_req  out  1  instruction memory read request
- imem_addr  out  WORDSIZE  read address, equals pc
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- pc  out  WORDSIZE  current PC
- pc_plus4  out  WORDSIZE  pc + 4, wraps modulo 2^WORDSIZE
- ir  out  32  instruction register
- opcode  out  7  ir[6:0]
- rd, rs1, rs2  out  5 each  ir[11:7], ir[19:15], ir[24:20]
- funct3  out  3  ir[14:12]
- funct7  out  7  ir[31:25]
- imm  out  WORDSIZE  sign-extended immediate decoded from ir
- instr_valid  out  1  ir holds a fetched, not yet retired instruction
- busy  out  1  high in REQ and VALID
- misalign  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- FSM states: IDLE, REQ, VALID. Reset: state IDLE, pc=RESET_PC, ir=32'h00000013 (NOP), instr_valid=0, imem_req=0, misalign=0.
- IDLE: fetch_start -> REQ. pc_we ignored.
- REQ: imem_req=1, imem_addr=pc held stable until ack. imem_ack -> ir<=imem_rdata, go VALID. fetch_start and pc_we ignored.
- VALID: instr_valid=1, ir stable. pc_we -> pc<=(pc_src ? pc_target : pc_plus4), instr_valid<=0, go IDLE. fetch_start ignored.
- fetch_start and pc_we together in VALID: pc_we honoured, fetch_start dropped.
- imem_ack outside REQ ignored (ir unchanged).
- imm decode by opcode, combinational from ir:
  - 0010011, 0000011, 1100111: sext(ir[31:20])
  - 0100011: sext({ir[31:25], ir[11:7]})
  - 1100011: sext({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0})
  - 0110111, 0010111: sext({ir[31:12], 12'b0})
  - 1101111: sext({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0})
  - all others (incl. 0110011, 1110011): 0
- Field outputs are pure slices of ir; valid whenever instr_valid=1.

## Timing
- imem_req asserts the cycle after fetch_start is sampled; minimum fetch latency fetch_start -> instr_valid is 2 cycles (ack in first REQ cycle).
- Memory may hold ack off indefinitely; imem_req stays high, no timeout.
- pc updates on the clock edge sampling pc_we; new pc and imem_addr visible next cycle.
- Reset asserted mid-REQ: imem_req drops asynchronously; a late ack after reset release is ignored.
- All outputs registered except decode fields, imm, pc_plus4, imem_addr (combinational from registers).

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: on pc_we with pc_src=1 and pc_target[1:0]!=2'b00, pc is not updated, misalign sets and stays set until reset, FSM still goes IDLE. Non-target updates unaffected.
- Undefined: pc_target[1:0] forced to 2'b00 on load; misalign tied 0.

## Test plan
- Reset with RESET_PC=0 -> pc=0, ir=32'h00000013, instr_valid=0, imem_req=0.
- fetch_start, ack after 3 wait cycles with 32'h00500093 -> imem_req high 4 cycles, imem_addr=0, opcode=7'b0010011, rd=1, imm=5, instr_valid high.
- Retire with pc_we, pc_src=0 -> pc=4; next fetch uses imem_addr=4.
- Fetch 32'hFE000EE3 (beq, offset -4) -> imm=64'hFFFF_FFFF_FFFF_FFFC; pc_we, pc_src=1, pc_target=0 -> pc=0.
- fetch_start and pc_we in same VALID cycle -> pc updated, state IDLE, imem_req stays 0.
- Macro defined: pc_we, pc_src=1, pc_target=6 -> pc unchanged, misalign=1; undefined -> pc=4, misalign=0.
